clock_step_controller: RTL and testbench

CLOCK_STEP_CONTROLLER -- requirements
Module: clock_step_controller

---
 rtl/clock_step_controller.sv | 161 ++++++++++++++++
 tb/tb_clock_step_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_step_controller.sv
// clock_step_controller: produces single-cycle CPU clock-enable pulses.
// In free-run mode the pulses follow rising edges of a divided clock. In manual
// mode each debounced press of a pushbutton gives one pulse. A halt request
// suppresses all pulses. Everything is clocked by CLK_IN, and the divided clock
// and the button are handled as asynchronous data.
module clock_step_controller #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             CLK_IN,
    input  logic             RESET,
    input  logic             SLOW_CLK_IN,
    input  logic             STEP_BTN,
    input  logic             MODE_RUN,
    input  logic             HALT,
    output logic             CPU_EN,
    output logic [CNT_W-1:0] STEP_COUNT,
    output logic [1:0]       STATE
);

    localparam logic [1:0] MANUAL = 2'b00;
    localparam logic [1:0] RUN    = 2'b01;
    localparam logic [1:0] HALTED = 2'b10;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             slow_meta;
    logic             slow_sync;
    logic             slow_prev;
    logic             slow_seen_low;
    logic             btn_meta;
    logic             btn_sync;
    logic [1:0]       settle;
    logic [CNT_W-1:0] deb_cnt;
    logic             btn_stable;
    logic             btn_armed;
    logic [1:0]       state;
    logic [1:0]       next_state;
    logic             slow_rise;
    logic             deb_fire;
    logic             step_req;
    logic             pulse;

    // Two-flop synchronizers for both asynchronous inputs. The settle shift
    // register marks when the synchronizer outputs hold real samples again
    // after a reset.
    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            slow_meta <= 1'b0;
            slow_sync <= 1'b0;
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            settle    <= 2'b00;
        end else begin
            slow_meta <= SLOW_CLK_IN;
            slow_sync <= slow_meta;
            btn_meta  <= STEP_BTN;
            btn_sync  <= btn_meta;
            settle    <= {settle[0], 1'b1};
        end
    end

    // Rising-edge register for the slow clock. Edges are honoured only after a
    // genuine low level has been seen following reset. This way a slow clock
    // that is high across a reset cannot show up as a fresh edge.
    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            slow_prev     <= 1'b0;
            slow_seen_low <= 1'b0;
        end else begin
            slow_prev <= slow_sync;
            if (settle[1] && !slow_sync) begin
                slow_seen_low <= 1'b1;
            end
        end
    end

    assign slow_rise = slow_sync & ~slow_prev & slow_seen_low;

    assign deb_fire = (btn_sync != btn_stable) && (deb_cnt == DEB_LAST);
    assign step_req = deb_fire & btn_sync & btn_armed;

    // Button debounce. The stable level moves only after a full run of
    // disagreeing samples. The arm flag needs a real released level, so a
    // button held through reset must be released before it can step.
    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            deb_cnt    <= '0;
            btn_stable <= 1'b0;
            btn_armed  <= 1'b0;
        end else begin
            if (btn_sync == btn_stable) begin
                deb_cnt <= '0;
            end else if (deb_fire) begin
                deb_cnt    <= '0;
                btn_stable <= btn_sync;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
            if (btn_stable) begin
                btn_armed <= 1'b0;
            end else if (settle[1] && !btn_sync) begin
                btn_armed <= 1'b1;
            end
        end
    end

    // Next-state logic. Halt dominates, and the unused encoding falls back to
    // manual mode.
    always_comb begin
        next_state = MANUAL;
        case (state)
            MANUAL: begin
                if (HALT)          next_state = HALTED;
                else if (MODE_RUN) next_state = RUN;
                else               next_state = MANUAL;
            end
            RUN: begin
                if (HALT)           next_state = HALTED;
                else if (!MODE_RUN) next_state = MANUAL;
                else                next_state = RUN;
            end
            HALTED: begin
                if (!HALT && !MODE_RUN) next_state = MANUAL;
                else                    next_state = HALTED;
            end
            default: next_state = MANUAL;
        endcase
    end

    // Pulse decision uses the current state. Halt vetoes it, and a pulse just
    // issued blocks a second one in the following cycle.
    always_comb begin
        pulse = 1'b0;
        case (state)
            MANUAL:  pulse = step_req;
            RUN:     pulse = slow_rise;
            default: pulse = 1'b0;
        endcase
        if (HALT || CPU_EN) begin
            pulse = 1'b0;
        end
    end

    // State register, registered enable pulse, and the wrapping step counter
    // that counts each pulse one cycle after it appears.
    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            state      <= MANUAL;
            CPU_EN     <= 1'b0;
            STEP_COUNT <= '0;
        end else begin
            state      <= next_state;
            CPU_EN     <= pulse;
            STEP_COUNT <= STEP_COUNT + {{(CNT_W-1){1'b0}}, CPU_EN};
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_clock_step_controller.sv
// tb_clock_step_controller: directed scenarios with a scoreboard of expected
// CPU_EN cycles. The counter is 8 bits wide so that the wrap case finishes quickly.
module tb_clock_step_controller;

    localparam int DEB = 4;
    localparam int CW  = 8;

    logic          CLK_IN = 1'b0;
    logic          RESET;
    logic          SLOW_CLK_IN;
    logic          STEP_BTN;
    logic          MODE_RUN;
    logic          HALT;
    logic          CPU_EN;
    logic [CW-1:0] STEP_COUNT;
    logic [1:0]    STATE;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            exp_q[$];
    logic [CW-1:0] exp_count;

    clock_step_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(CW)
    ) dut (
        .CLK_IN(CLK_IN),
        .RESET(RESET),
        .SLOW_CLK_IN(SLOW_CLK_IN),
        .STEP_BTN(STEP_BTN),
        .MODE_RUN(MODE_RUN),
        .HALT(HALT),
        .CPU_EN(CPU_EN),
        .STEP_COUNT(STEP_COUNT),
        .STATE(STATE)
    );

    // Free-running system clock.
    always #5 CLK_IN = ~CLK_IN;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A pulse is expected exactly when the head of the scoreboard names this cycle.
    task automatic monitorCycle();
        logic exp_en;
        exp_en = (exp_q.size() > 0) && (exp_q[0] == cyc);
        if (exp_en || CPU_EN) begin
            checkOutput("cpu_en", 32'(CPU_EN), 32'(exp_en));
            if (exp_en) begin
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK_IN);
            cyc++;
            monitorCycle();
        end
    endtask

    task automatic expectPulse(input int delay);
        exp_q.push_back(cyc + delay);
        exp_count = exp_count + CW'(1);
    endtask

    task automatic applyStimulus(input logic slow, input logic btn, input logic mode,
                                 input logic halt, input int n);
        SLOW_CLK_IN = slow;
        STEP_BTN    = btn;
        MODE_RUN    = mode;
        HALT        = halt;
        tick(n);
    endtask

    task automatic applyReset();
        RESET = 1'b1;
        tick(2);
        RESET     = 1'b0;
        exp_count = '0;
    endtask

    initial begin
        RESET       = 1'b1;
        SLOW_CLK_IN = 1'b0;
        STEP_BTN    = 1'b0;
        MODE_RUN    = 1'b0;
        HALT        = 1'b0;
        exp_count   = '0;
        tick(2);
        RESET = 1'b0;
        checkOutput("reset_state", 32'(STATE), 32'd0);
        checkOutput("reset_cpu_en", 32'(CPU_EN), 32'd0);
        checkOutput("reset_count", 32'(STEP_COUNT), 32'd0);

        // Free-run: four slow-clock rising edges, each pulse three ticks after the drive.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5);
        checkOutput("run_state", 32'(STATE), 32'd1);
        for (int i = 0; i < 4; i++) begin
            SLOW_CLK_IN = 1'b1;
            expectPulse(3);
            tick(8);
            SLOW_CLK_IN = 1'b0;
            tick(8);
        end
        checkOutput("run_count", 32'(STEP_COUNT), 32'd4);
        checkOutput("run_pending", 32'(exp_q.size()), 32'd0);

        // Manual: bouncing button, then a solid press gives exactly one step.
        applyReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5);
        for (int i = 0; i < 10; i++) begin
            STEP_BTN = (i % 2 == 0);
            tick(2);
        end
        STEP_BTN = 1'b1;
        expectPulse(DEB + 2);
        tick(10);
        checkOutput("bounce_count", 32'(STEP_COUNT), 32'd1);
        checkOutput("bounce_state", 32'(STATE), 32'd0);
        checkOutput("bounce_pending", 32'(exp_q.size()), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10);

        // Halt arrives in the same cycle the slow edge is detected.
        applyReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5);
        SLOW_CLK_IN = 1'b1;
        tick(2);
        HALT = 1'b1;
        tick(1);
        checkOutput("halt_state", 32'(STATE), 32'd2);
        tick(3);
        checkOutput("halt_hold", 32'(STATE), 32'd2);
        checkOutput("halt_count", 32'(STEP_COUNT), 32'd0);
        HALT     = 1'b0;
        MODE_RUN = 1'b0;
        tick(1);
        checkOutput("unhalt_state", 32'(STATE), 32'd0);
        SLOW_CLK_IN = 1'b0;
        tick(4);
        checkOutput("halt_pending", 32'(exp_q.size()), 32'd0);

        // Counter wrap: all-ones followed by zero.
        applyReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5);
        for (int i = 0; i < (1 << CW) - 1; i++) begin
            SLOW_CLK_IN = 1'b1;
            expectPulse(3);
            tick(1);
            SLOW_CLK_IN = 1'b0;
            tick(1);
        end
        tick(5);
        checkOutput("count_all_ones", 32'(STEP_COUNT), 32'((1 << CW) - 1));
        checkOutput("count_model", 32'(STEP_COUNT), 32'(exp_count));
        SLOW_CLK_IN = 1'b1;
        expectPulse(3);
        tick(1);
        SLOW_CLK_IN = 1'b0;
        tick(5);
        checkOutput("count_wrap", 32'(STEP_COUNT), 32'd0);
        checkOutput("wrap_pending", 32'(exp_q.size()), 32'd0);

        // Button held across reset must not step until it is released and pressed again.
        MODE_RUN = 1'b0;
        STEP_BTN = 1'b1;
        tick(3);
        applyReset();
        tick(20);
        checkOutput("held_count", 32'(STEP_COUNT), 32'd0);
        checkOutput("held_pending", 32'(exp_q.size()), 32'd0);
        STEP_BTN = 1'b0;
        tick(10);
        STEP_BTN = 1'b1;
        expectPulse(DEB + 2);
        tick(10);
        checkOutput("repress_count", 32'(STEP_COUNT), 32'd1);
        checkOutput("repress_pending", 32'(exp_q.size()), 32'd0);
        STEP_BTN = 1'b0;
        tick(10);

        // Reset one cycle after a slow-clock rise discards that edge.
        applyReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5);
        SLOW_CLK_IN = 1'b1;
        expectPulse(3);
        tick(8);
        SLOW_CLK_IN = 1'b0;
        tick(8);
        checkOutput("pre_reset_count", 32'(STEP_COUNT), 32'd1);
        SLOW_CLK_IN = 1'b1;
        tick(1);
        RESET    = 1'b1;
        MODE_RUN = 1'b0;
        tick(1);
        RESET     = 1'b0;
        exp_count = '0;
        checkOutput("midreset_state", 32'(STATE), 32'd0);
        checkOutput("midreset_count", 32'(STEP_COUNT), 32'd0);
        tick(10);
        checkOutput("postreset_state", 32'(STATE), 32'd0);
        checkOutput("postreset_count", 32'(STEP_COUNT), 32'd0);
        checkOutput("postreset_pending", 32'(exp_q.size()), 32'd0);
        SLOW_CLK_IN = 1'b0;
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
